// File: rtl/mux8_scan_pkg.sv
// Shared constants for the mux8 scan sequencer: state encoding, channel count,
// settle-counter width and default settle length.
package mux8_scan_pkg;
    localparam int NUM_CH     = 8;
    localparam int SCNT_W     = 4;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_DWELL  = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/mux8_next_pick.sv
// Next-enabled-channel picker: lowest enabled index above cur, or lowest
// enabled index overall when cur is 7 (wrap). none is set when nothing qualifies.
import mux8_scan_pkg::*;

module mux8_next_pick (
    input  logic [NUM_CH-1:0] mask,
    input  logic [2:0]        cur,
    output logic [2:0]        nxt,
    output logic              none
);
    always_comb begin
        nxt  = 3'd0;
        none = 1'b1;
        // Descending scan so the lowest qualifying index is written last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (cur == 3'd7 || i > int'(cur))) begin
                nxt  = 3'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for the 8:1 sense mux: settle, dwell and OR-accumulate per
// enabled channel, then hand off an 8-bit frame. MUX8_SCAN_FORCE_EN adds an
// IDLE-only manual select override.
import mux8_scan_pkg::*;

module mux8_scan_ctrl #(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               continuous,
    input  logic [NUM_CH-1:0]  enable_mask,
    input  logic [DWELL_W-1:0] dwell,
`ifdef MUX8_SCAN_FORCE_EN
    input  logic               force_en,
    input  logic [2:0]         force_sel,
`endif
    output logic [2:0]         sel,
    input  logic               y_in,
    output logic               busy,
    output logic [NUM_CH-1:0]  frame,
    output logic               frame_valid,
    input  logic               frame_ready
);
    // A zero settle skips the SETTLE state entirely.
    localparam state_t POST_SEL = (SETTLE == 0) ? S_DWELL : S_SETTLE;

    state_t             state, state_n;
    logic [2:0]         sel_n;
    logic [NUM_CH-1:0]  mask_q, mask_n, acc, acc_n, frame_n;
    logic               fv_n;
    logic [SCNT_W-1:0]  scnt, scnt_n;
    logic [DWELL_W-1:0] dwl_q, dwl_n, dcnt, dcnt_n;
    logic               dlast, first_pick, force_on;
    logic [2:0]         force_val;
    logic [NUM_CH-1:0]  pick_mask;
    logic [2:0]         pick_cur, pick_idx;
    logic               pick_none;

`ifdef MUX8_SCAN_FORCE_EN
    assign force_on  = force_en;
    assign force_val = force_sel;
`else
    assign force_on  = 1'b0;
    assign force_val = 3'd0;
`endif

    // One picker serves both the first-channel (live mask, wrap) and
    // next-channel (latched mask, current sel) decisions.
    assign first_pick = (state == S_IDLE) || (state == S_DONE);
    assign pick_mask  = first_pick ? enable_mask : mask_q;
    assign pick_cur   = first_pick ? 3'd7 : sel;

    mux8_next_pick u_pick (
        .mask (pick_mask),
        .cur  (pick_cur),
        .nxt  (pick_idx),
        .none (pick_none)
    );

    assign dlast = (dwl_q == '0) || (dcnt == dwl_q - 1'b1);
    assign busy  = (state != S_IDLE);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        mask_n  = mask_q;
        dwl_n   = dwl_q;
        acc_n   = acc;
        frame_n = frame;
        fv_n    = frame_valid;
        scnt_n  = scnt;
        dcnt_n  = dcnt;
        case (state)
            S_IDLE: begin
                sel_n = force_on ? force_val : 3'd0;
                if (start && !force_on && enable_mask != '0) begin
                    mask_n  = enable_mask;
                    dwl_n   = dwell;
                    acc_n   = '0;
                    sel_n   = pick_idx;
                    scnt_n  = '0;
                    dcnt_n  = '0;
                    state_n = POST_SEL;
                end
            end
            S_SETTLE: begin
                if (scnt == SCNT_W'(SETTLE - 1)) begin
                    scnt_n  = '0;
                    state_n = S_DWELL;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            S_DWELL: begin
                acc_n[sel] = acc[sel] | y_in;
                if (dlast) begin
                    dcnt_n  = '0;
                    state_n = S_NEXT;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            S_NEXT: begin
                if (!pick_none && sel != 3'd7) begin
                    sel_n   = pick_idx;
                    state_n = POST_SEL;
                end else begin
                    frame_n = acc;
                    fv_n    = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (frame_ready) begin
                    fv_n = 1'b0;
                    if (continuous && enable_mask != '0) begin
                        mask_n  = enable_mask;
                        dwl_n   = dwell;
                        acc_n   = '0;
                        sel_n   = pick_idx;
                        state_n = POST_SEL;
                    end else begin
                        sel_n   = 3'd0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                sel_n   = 3'd0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel         <= 3'd0;
            mask_q      <= '0;
            dwl_q       <= '0;
            acc         <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            scnt        <= '0;
            dcnt        <= '0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            mask_q      <= mask_n;
            dwl_q       <= dwl_n;
            acc         <= acc_n;
            frame       <= frame_n;
            frame_valid <= fv_n;
            scnt        <= scnt_n;
            dcnt        <= dcnt_n;
        end
    end
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: expected frames are queued at start and
// compared when frame_valid rises; timing and control outputs checked inline.
module tb_mux8_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, continuous, frame_ready;
    logic [7:0] enable_mask, frame, ymask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       y_in, busy, frame_valid;
    logic       y_force, y_val;
`ifdef MUX8_SCAN_FORCE_EN
    logic       force_en;
    logic [2:0] force_sel;
`endif

    logic [7:0] exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    assign y_in = y_force ? y_val : ymask[sel];

    mux8_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .enable_mask (enable_mask),
        .dwell       (dwell),
`ifdef MUX8_SCAN_FORCE_EN
        .force_en    (force_en),
        .force_sel   (force_sel),
`endif
        .sel         (sel),
        .y_in        (y_in),
        .busy        (busy),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_frame"}, 32'(frame), 32'(e));
        end
    endtask

    task automatic wait_frame(input string tag, input int budget, output int lat);
        lat = 0;
        while (!frame_valid && lat < budget) begin
            tick();
            lat++;
        end
        chk({tag, "_fv_timeout"}, 32'(frame_valid), 1);
        check_frame(tag);
    endtask

    task automatic handshake(input string tag);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk({tag, "_fv_clear"}, 32'(frame_valid), 0);
    endtask

    initial begin
        int lat, c, nvis;
        logic [2:0] vis[8];

        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; frame_ready = 1'b0;
        enable_mask = '0; dwell = '0; ymask = '0; y_force = 1'b0; y_val = 1'b0;
`ifdef MUX8_SCAN_FORCE_EN
        force_en = 1'b0; force_sel = '0;
`endif
        tick(2);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        rst_n = 1'b1;
        tick();

        // Single channel, pulse in 2nd dwell cycle (cycle 4)
        enable_mask = 8'h10; dwell = 8'd3; y_force = 1'b1; y_val = 1'b0;
        start = 1'b1; exp_q.push_back(8'h10);
        tick(); start = 1'b0;
        chk("t1_sel_c1", 32'(sel), 4);
        chk("t1_busy_c1", 32'(busy), 1);
        tick(3); y_val = 1'b1;
        tick(); y_val = 1'b0;
        tick();
        chk("t1_fv_c6", 32'(frame_valid), 0);
        tick();
        chk("t1_fv_c7", 32'(frame_valid), 1);
        check_frame("t1");
        handshake("t1");
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_sel", 32'(sel), 0);

        // y high only during SETTLE and NEXT: must not be sampled
        y_val = 1'b1; start = 1'b1; exp_q.push_back(8'h00);
        tick(); start = 1'b0;
        tick(2); y_val = 1'b0;
        tick(3); y_val = 1'b1;
        tick(); y_val = 1'b0;
        chk("t1b_fv_c7", 32'(frame_valid), 1);
        check_frame("t1b");
        handshake("t1b");
        y_force = 1'b0;

        // Sparse mask, held y; mid-frame mask/dwell changes and start ignored
        enable_mask = 8'hA5; dwell = 8'd2; ymask = 8'h81;
        start = 1'b1; exp_q.push_back(8'hA5 & 8'h81);
        tick(); start = 1'b0; enable_mask = 8'hFF; dwell = 8'd0;
        vis[0] = sel; nvis = 1; c = 1;
        while (!frame_valid && c < 100) begin
            if (c == 3) start = 1'b1;
            tick(); c++;
            start = 1'b0;
            if (!frame_valid && sel != vis[nvis-1] && nvis < 8) begin
                vis[nvis] = sel;
                nvis++;
            end
        end
        chk("t2_nvis", 32'(nvis), 4);
        chk("t2_vis0", 32'(vis[0]), 0);
        chk("t2_vis1", 32'(vis[1]), 2);
        chk("t2_vis2", 32'(vis[2]), 5);
        chk("t2_vis3", 32'(vis[3]), 7);
        chk("t2_latency", 32'(c), 21);
        check_frame("t2");
        handshake("t2");

        // Zero mask start is ignored
        enable_mask = 8'h00; start = 1'b1;
        tick(); start = 1'b0;
        chk("t3_zero_busy", 32'(busy), 0);
        chk("t3_zero_sel", 32'(sel), 0);
        tick();
        chk("t3_zero_busy2", 32'(busy), 0);

        // Dwell 0 observes each channel for exactly 1 cycle
        enable_mask = 8'h06; dwell = 8'd0; ymask = 8'h04;
        start = 1'b1; exp_q.push_back(8'h04);
        tick(); start = 1'b0;
        wait_frame("t3_d0", 50, lat);
        chk("t3_d0_latency", 32'(lat + 1), 9);
        handshake("t3_d0");

        // Backpressure then continuous restart
        enable_mask = 8'h08; dwell = 8'd1; ymask = 8'h28; continuous = 1'b1;
        start = 1'b1; exp_q.push_back(8'h08);
        tick(); start = 1'b0;
        wait_frame("t4a", 50, lat);
        chk("t4a_latency", 32'(lat + 1), 5);
        y_force = 1'b1;
        for (int i = 0; i < 10; i++) begin
            y_val = ~y_val;
            tick();
            chk("t4_bp_fv", 32'(frame_valid), 1);
            chk("t4_bp_frame", 32'(frame), 'h08);
        end
        y_force = 1'b0; enable_mask = 8'h30; exp_q.push_back(8'h20);
        frame_ready = 1'b1;
        tick(); frame_ready = 1'b0; continuous = 1'b0;
        chk("t4_hs_fv", 32'(frame_valid), 0);
        chk("t4_restart_busy", 32'(busy), 1);
        chk("t4_restart_sel", 32'(sel), 4);
        wait_frame("t4b", 50, lat);
        chk("t4b_latency", 32'(lat + 1), 9);
        handshake("t4b");
        chk("t4b_idle", 32'(busy), 0);

        // Reset mid-DWELL on channel 3 (cycles 11..15), then a fresh frame
        enable_mask = 8'h0C; dwell = 8'd5; ymask = 8'h0C;
        start = 1'b1;
        tick(); start = 1'b0;
        tick(11);
        chk("t5_sel_c12", 32'(sel), 3);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_sel", 32'(sel), 0);
        chk("t5_rst_frame", 32'(frame), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        tick(); rst_n = 1'b1;
        tick();
        ymask = 8'h04;
        start = 1'b1; exp_q.push_back(8'h04);
        tick(); start = 1'b0;
        wait_frame("t5", 60, lat);
        chk("t5_latency", 32'(lat + 1), 17);
        handshake("t5");

`ifdef MUX8_SCAN_FORCE_EN
        force_en = 1'b1; force_sel = 3'd6;
        tick();
        chk("t6_force_sel", 32'(sel), 6);
        enable_mask = 8'h01; start = 1'b1;
        tick(); start = 1'b0;
        chk("t6_force_busy", 32'(busy), 0);
        chk("t6_force_sel2", 32'(sel), 6);
        force_en = 1'b0;
        tick();
        chk("t6_release_sel", 32'(sel), 0);
`endif

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
